// File: rtl/lbus_byte_slave.sv
// Main-FPGA byte-link slave: decodes command byte frames into 16-bit local-bus cycles and returns read data.
// Optional macro LBUS_FRAME_TIMEOUT_EN drops partial frames after TIMEOUT_CYC idle cycles.
module lbus_byte_slave #(
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        WRDYn,
    input  logic        DWE,
    input  logic [7:0]  DIN,
    output logic        RRDYn,
    input  logic        DRE,
    output logic [7:0]  DOUT,
    output logic [15:0] BUS_ADDR,
    output logic [15:0] BUS_WDATA,
    output logic        BUS_WR,
    output logic        BUS_RD,
    input  logic [15:0] BUS_RDATA,
    output logic        BAD_CMD
);

    typedef enum logic [3:0] {
        S_CMD, S_AH, S_AL, S_DH, S_DL, S_WR, S_RD, S_RWAIT, S_TXH, S_TXL
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_hi_q, wdata_hi_d;
    logic [7:0]  rdata_lo_q, rdata_lo_d;
    logic [3:0]  lat_q, lat_d;

    logic        wrdy_n_d, rrdy_n_d, bus_wr_d, bus_rd_d, bad_d;
    logic [7:0]  dout_d;
    logic [15:0] bus_addr_d, bus_wdata_d;

`ifdef LBUS_FRAME_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 12) ? $clog2(TIMEOUT_CYC + 1) : 12;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_wr_d    = cmd_wr_q;
        addr_d      = addr_q;
        wdata_hi_d  = wdata_hi_q;
        rdata_lo_d  = rdata_lo_q;
        lat_d       = lat_q;
        rrdy_n_d    = RRDYn;
        dout_d      = DOUT;
        bus_addr_d  = BUS_ADDR;
        bus_wdata_d = BUS_WDATA;
        bus_wr_d    = 1'b0;
        bus_rd_d    = 1'b0;
        bad_d       = BAD_CMD;

        case (state_q)
            S_CMD: if (DWE) begin
                if (DIN == 8'h01) begin
                    cmd_wr_d = 1'b1;
                    state_d  = S_AH;
                end else if (DIN == 8'h00) begin
                    cmd_wr_d = 1'b0;
                    state_d  = S_AH;
                end else begin
                    bad_d = 1'b1;
                end
            end
            S_AH: if (DWE) begin
                addr_d[15:8] = DIN;
                state_d      = S_AL;
            end
            S_AL: if (DWE) begin
                addr_d[7:0] = DIN;
                if (cmd_wr_q) begin
                    state_d = S_DH;
                end else begin
                    bus_addr_d = {addr_q[15:8], DIN};
                    bus_rd_d   = 1'b1;
                    state_d    = S_RD;
                end
            end
            S_DH: if (DWE) begin
                wdata_hi_d = DIN;
                state_d    = S_DL;
            end
            S_DL: if (DWE) begin
                bus_addr_d  = addr_q;
                bus_wdata_d = {wdata_hi_q, DIN};
                bus_wr_d    = 1'b1;
                state_d     = S_WR;
            end
            S_WR: state_d = S_CMD;
            S_RD: begin
                lat_d   = 4'd1;
                state_d = S_RWAIT;
            end
            // lat_q counts cycles since the BUS_RD pulse; capture when it equals RD_LAT
            S_RWAIT: begin
                if (lat_q == 4'(RD_LAT)) begin
                    rdata_lo_d = BUS_RDATA[7:0];
                    dout_d     = BUS_RDATA[15:8];
                    rrdy_n_d   = 1'b0;
                    state_d    = S_TXH;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_TXH: if (DRE) begin
                dout_d  = rdata_lo_q;
                state_d = S_TXL;
            end
            S_TXL: if (DRE) begin
                rrdy_n_d = 1'b1;
                state_d  = S_CMD;
            end
            default: state_d = S_CMD;
        endcase

`ifdef LBUS_FRAME_TIMEOUT_EN
        to_cnt_d = '0;
        if ((state_q == S_AH || state_q == S_AL || state_q == S_DH || state_q == S_DL) && !DWE) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                state_d = S_CMD;
                bad_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif

        wrdy_n_d = !(state_d == S_CMD || state_d == S_AH || state_d == S_AL ||
                     state_d == S_DH  || state_d == S_DL);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_CMD;
            WRDYn     <= 1'b1;
            RRDYn     <= 1'b1;
            DOUT      <= 8'h00;
            BUS_ADDR  <= 16'h0000;
            BUS_WDATA <= 16'h0000;
            BUS_WR    <= 1'b0;
            BUS_RD    <= 1'b0;
            BAD_CMD   <= 1'b0;
            lat_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            WRDYn     <= wrdy_n_d;
            RRDYn     <= rrdy_n_d;
            DOUT      <= dout_d;
            BUS_ADDR  <= bus_addr_d;
            BUS_WDATA <= bus_wdata_d;
            BUS_WR    <= bus_wr_d;
            BUS_RD    <= bus_rd_d;
            BAD_CMD   <= bad_d;
            lat_q     <= lat_d;
        end
    end

    // Frame shadow registers carry data only; the FSM decides when they are meaningful
    always_ff @(posedge CLK) begin
        cmd_wr_q   <= cmd_wr_d;
        addr_q     <= addr_d;
        wdata_hi_q <= wdata_hi_d;
        rdata_lo_q <= rdata_lo_d;
    end

`ifdef LBUS_FRAME_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`endif

endmodule
